// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one lock/round-robin arbiter per output, heads allocate
// a free output, body/tail flits stream through the owner until the tail releases it.
module switch_alloc_out #(
    parameter int NUM_OF_PORTS = 5,
    parameter int PORT_BITS    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_OF_PORTS-1:0] elig,
    input  logic [NUM_OF_PORTS-1:0] req_ok,
    input  logic [NUM_OF_PORTS-1:0] is_tail,
    input  logic                    out_ready,
    output logic                    locked,
    output logic [PORT_BITS-1:0]    owner,
    output logic [NUM_OF_PORTS-1:0] grant_vec,
    output logic [PORT_BITS-1:0]    xbar_sel,
    output logic                    xbar_valid
);
    localparam logic [PORT_BITS-1:0] NONE_PORT = PORT_BITS'(NUM_OF_PORTS);
    localparam logic [PORT_BITS-1:0] RR_INIT   = PORT_BITS'(NUM_OF_PORTS - 1);

    typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [PORT_BITS-1:0] owner_nxt, rr, rr_nxt, win, idx;
    logic                 found;

    // Search starts just after the last packet's owner so it gets lowest priority next.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_OF_PORTS; k++) begin
            idx = PORT_BITS'((int'(rr) + k) % NUM_OF_PORTS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
            owner <= '0;
            rr    <= RR_INIT;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_nxt     = rr;
        grant_vec  = '0;
        xbar_sel   = NONE_PORT;
        xbar_valid = 1'b0;
        case (state)
            FREE: begin
                // Allocation cycle only; the head itself moves on the following cycle.
                if (found) begin
                    state_nxt = LOCKED;
                    owner_nxt = win;
                end
            end
            LOCKED: begin
                xbar_sel = owner;
                if (req_ok[owner] && out_ready) begin
                    grant_vec[owner] = 1'b1;
                    xbar_valid       = 1'b1;
                    if (is_tail[owner]) begin
                        state_nxt = FREE;
                        rr_nxt    = owner;
                    end
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    assign locked = (state == LOCKED);
endmodule

module switch_allocator #(
    parameter int NUM_OF_PORTS = 5,
    parameter int PORT_BITS    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_OF_PORTS-1:0]                req_i,
    input  logic [NUM_OF_PORTS-1:0][PORT_BITS-1:0] req_port_i,
    input  logic [NUM_OF_PORTS-1:0][1:0]           req_flit_type_i,
    input  logic [NUM_OF_PORTS-1:0]                out_ready_i,
    output logic [NUM_OF_PORTS-1:0]                grant_o,
    output logic [NUM_OF_PORTS-1:0][PORT_BITS-1:0] xbar_sel_o,
    output logic [NUM_OF_PORTS-1:0]                xbar_valid_o,
    output logic [NUM_OF_PORTS-1:0]                out_busy_o,
    output logic                                   protocol_err_o
);
    localparam logic [1:0]           HEAD  = 2'd0;
    localparam logic [1:0]           TAIL  = 2'd1;
    localparam logic [PORT_BITS-1:0] NPORT = PORT_BITS'(NUM_OF_PORTS);

    logic [NUM_OF_PORTS-1:0]                   locked, owns, port_ok, req_ok, is_tail, viol;
    logic [NUM_OF_PORTS-1:0][PORT_BITS-1:0]    owner;
    logic [NUM_OF_PORTS-1:0][NUM_OF_PORTS-1:0] elig, grant_vec;

    always_comb begin
        owns = '0;
        for (int o = 0; o < NUM_OF_PORTS; o++)
            if (locked[o]) owns[owner[o]] = 1'b1;
    end

    // An input already holding a lock is kept out of allocation so it can never be
    // granted by two outputs at once.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            port_ok[i] = req_port_i[i] < NPORT;
            req_ok[i]  = req_i[i] && port_ok[i];
            is_tail[i] = req_flit_type_i[i] == TAIL;
            viol[i]    = req_i[i] && (!port_ok[i] || (req_flit_type_i[i] != HEAD && !owns[i]));
            for (int o = 0; o < NUM_OF_PORTS; o++)
                elig[o][i] = req_ok[i] && req_port_i[i] == PORT_BITS'(o) &&
                             req_flit_type_i[i] == HEAD && !owns[i];
        end
    end

    for (genvar g = 0; g < NUM_OF_PORTS; g++) begin : g_out
        switch_alloc_out #(
            .NUM_OF_PORTS(NUM_OF_PORTS),
            .PORT_BITS   (PORT_BITS)
        ) u_out (
            .clk       (clk),
            .rst_n     (rst_n),
            .elig      (elig[g]),
            .req_ok    (req_ok),
            .is_tail   (is_tail),
            .out_ready (out_ready_i[g]),
            .locked    (locked[g]),
            .owner     (owner[g]),
            .grant_vec (grant_vec[g]),
            .xbar_sel  (xbar_sel_o[g]),
            .xbar_valid(xbar_valid_o[g])
        );
    end

    always_comb begin
        grant_o = '0;
        for (int o = 0; o < NUM_OF_PORTS; o++) grant_o = grant_o | grant_vec[o];
    end

    assign out_busy_o = locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) protocol_err_o <= 1'b0;
        else        protocol_err_o <= |viol;
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: per-input packet queues drive the DUT, a per-output
// lock/owner/round-robin model predicts every output each cycle.
module tb_switch_allocator;
    typedef struct packed {logic [2:0] port; logic [1:0] typ;} flit_t;

    logic            clk, rst_n;
    logic [4:0]      req_i, out_ready_i, grant_o, xbar_valid_o, out_busy_o;
    logic [4:0][2:0] req_port_i, xbar_sel_o;
    logic [4:0][1:0] req_flit_type_i;
    logic            protocol_err_o;

    switch_allocator dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_port_i(req_port_i),
        .req_flit_type_i(req_flit_type_i), .out_ready_i(out_ready_i), .grant_o(grant_o),
        .xbar_sel_o(xbar_sel_o), .xbar_valid_o(xbar_valid_o), .out_busy_o(out_busy_o),
        .protocol_err_o(protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    flit_t q[5][$];
    bit frc[5], hold[5];
    logic [2:0] fp[5];
    logic [1:0] ft[5];
    logic [4:0] rdy;
    int m_lock[5], m_own[5], m_rr[5];
    bit m_err;
    logic [4:0] egh[$], evh[$];
    bit errh[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_pkt(int i, int port, int len);
        flit_t f;
        f.port = 3'(port);
        for (int k = 0; k < len; k++) begin
            f.typ = (k == 0) ? 2'd0 : (k == len - 1) ? 2'd1 : 2'd2;
            q[i].push_back(f);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin m_lock[o] = 0; m_own[o] = 0; m_rr[o] = 4; end
        m_err = 0;
    endtask

    // Asserts reset asynchronously at the current time, checks the reset state, and
    // releases on a later falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0; req_port_i = '0; req_flit_type_i = '1; rdy = '1; out_ready_i = '1;
        for (int i = 0; i < 5; i++) begin q[i].delete(); frc[i] = 0; hold[i] = 0; end
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_valid", xbar_valid_o, 0);
        chk("rst_busy", out_busy_o, 0);
        chk("rst_sel", xbar_sel_o, 15'b101101101101101);
        chk("rst_err", protocol_err_o, 0);
        model_reset();
        egh.delete(); evh.delete(); errh.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        int pt[5], ty[5], nl[5], no[5], nr[5];
        bit owns[5], viol, found;
        logic [4:0] rq, eg, ev, eb;
        logic [14:0] es;
        int w, c;
        for (int i = 0; i < 5; i++) begin
            if (frc[i]) begin
                req_i[i] = 1'b1; req_port_i[i] = fp[i]; req_flit_type_i[i] = ft[i];
            end else if (q[i].size() > 0 && !hold[i]) begin
                req_i[i] = 1'b1; req_port_i[i] = q[i][0].port; req_flit_type_i[i] = q[i][0].typ;
            end else begin
                req_i[i] = 1'b0; req_port_i[i] = 3'd0; req_flit_type_i[i] = 2'd3;
            end
        end
        out_ready_i = rdy;
        #1;
        rq = req_i;
        for (int i = 0; i < 5; i++) begin
            pt[i] = int'(req_port_i[i]); ty[i] = int'(req_flit_type_i[i]); owns[i] = 0;
        end
        for (int o = 0; o < 5; o++) if (m_lock[o] != 0) owns[m_own[o]] = 1;
        viol = 0;
        for (int i = 0; i < 5; i++)
            if (rq[i] && (pt[i] > 4 || (ty[i] != 0 && !owns[i]))) viol = 1;
        eg = '0; ev = '0; eb = '0; es = 15'b101101101101101;
        for (int o = 0; o < 5; o++) begin
            nl[o] = m_lock[o]; no[o] = m_own[o]; nr[o] = m_rr[o];
            if (m_lock[o] != 0) begin
                w = m_own[o];
                eb[o] = 1'b1;
                es[o*3 +: 3] = 3'(w);
                if (rq[w] && pt[w] <= 4 && rdy[o]) begin
                    eg[w] = 1'b1; ev[o] = 1'b1;
                    if (ty[w] == 1) begin nl[o] = 0; nr[o] = w; end
                end
            end else begin
                found = 0;
                for (int k = 1; k <= 5; k++) begin
                    c = (m_rr[o] + k) % 5;
                    if (!found && rq[c] && pt[c] == o && ty[c] == 0 && !owns[c]) begin
                        found = 1; nl[o] = 1; no[o] = c;
                    end
                end
            end
        end
        chk("grant", grant_o, eg);
        chk("valid", xbar_valid_o, ev);
        chk("busy", out_busy_o, eb);
        chk("sel", xbar_sel_o, es);
        chk("perr", protocol_err_o, m_err);
        egh.push_back(eg); evh.push_back(ev); errh.push_back(m_err);
        for (int o = 0; o < 5; o++) begin m_lock[o] = nl[o]; m_own[o] = no[o]; m_rr[o] = nr[o]; end
        m_err = viol;
        for (int i = 0; i < 5; i++) if (eg[i] && !frc[i]) void'(q[i].pop_front());
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [15:0] gpat(int i);
        gpat = '0;
        for (int k = 0; k < egh.size() && k < 16; k++) gpat[k] = egh[k][i];
    endfunction

    function automatic logic [15:0] vpat(int o);
        vpat = '0;
        for (int k = 0; k < evh.size() && k < 16; k++) vpat[k] = evh[k][o];
    endfunction

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Single packet LOCAL -> EAST, four flits.
        push_pkt(0, 3, 4);
        repeat (6) step();
        chk("pkt_grant0", gpat(0), 16'b011110);
        chk("pkt_valid3", vpat(3), 16'b011110);
        chk("pkt_rr3", m_rr[3], 0);
        chk("pkt_unlock3", m_lock[3], 0);

        // Three inputs contend for WEST from reset.
        do_reset();
        push_pkt(1, 4, 2); push_pkt(2, 4, 2); push_pkt(4, 4, 2);
        repeat (10) step();
        chk("rr_in1", gpat(1), 16'b0000000110);
        chk("rr_in2", gpat(2), 16'b0000110000);
        chk("rr_in4", gpat(4), 16'b0110000000);
        chk("rr_valid4", vpat(4), 16'b0110110110);

        // Output stalls mid-packet.
        do_reset();
        push_pkt(0, 2, 4);
        begin
            logic [6:0] rp;
            rp = 7'b1110011;
            for (int k = 0; k < 7; k++) begin rdy = '1; rdy[2] = rp[k]; step(); end
        end
        chk("stall_grant0", gpat(0), 16'b1110010);
        chk("stall_unlock2", m_lock[2], 0);

        // Parallel allocation of NORTH and SOUTH.
        do_reset();
        push_pkt(0, 1, 2); push_pkt(3, 2, 2);
        repeat (3) step();
        chk("par_c1", egh[1], 5'b01001);
        chk("par_c2", egh[2], 5'b01001);

        // BODY from an idle input.
        do_reset();
        frc[2] = 1; fp[2] = 3'd1; ft[2] = 2'd2;
        step();
        frc[2] = 0;
        repeat (2) step();
        chk("perr_pulse", {29'd0, errh[2], errh[1], errh[0]}, 3'b010);
        chk("perr_nolock", {m_lock[0][0], m_lock[1][0], m_lock[2][0], m_lock[3][0], m_lock[4][0]}, 0);

        // Reset in the middle of a WEST packet, then fresh contention.
        do_reset();
        push_pkt(3, 4, 4);
        repeat (3) step();
        chk("mid_busy_pre", out_busy_o, 5'b10000);
        do_reset();
        push_pkt(1, 4, 2); push_pkt(0, 4, 2);
        repeat (3) step();
        chk("mid_winner", egh[1], 5'b00001);

        // Randomized traffic with stalls, gaps and occasional malformed requests.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit owns[5];
            for (int i = 0; i < 5; i++) owns[i] = 0;
            for (int o = 0; o < 5; o++) if (m_lock[o] != 0) owns[m_own[o]] = 1;
            for (int i = 0; i < 5; i++) begin
                if (q[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, $urandom_range(4), $urandom_range(2, 5));
                hold[i] = ($urandom_range(7) == 0);
                frc[i]  = !owns[i] && ($urandom_range(29) == 0);
                fp[i]   = $urandom_range(1) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(4));
                ft[i]   = 2'($urandom_range(1, 3));
            end
            rdy = 5'($urandom);
            if (n % 500 < 60) rdy = '1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
- REQ-001: Parameter NUM_OF_PORTS, default 5, number of router input ports and output ports; index order is LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- REQ-002: Parameter PORT_BITS, default 3, width of a PORT_t code; NONE_PORT=5.
- REQ-003: clk  input  1  single clock, all state on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: req_i  input  5  input port i has a valid flit at its buffer head.
- REQ-006: req_port_i  input  5x3  PORT_t target output of input i's head flit.
- REQ-007: req_flit_type_i  input  5x2  FLIT_TYPE_t of input i's buffer-head flit (HEAD=0, TAIL=1, BODY=2, NONE=3).
- REQ-008: out_ready_i  input  5  output o's downstream can accept one flit this cycle.
- REQ-009: grant_o  output  5  switch_ack: input i's flit is transferred this cycle; input pops its flit.
- REQ-010: xbar_sel_o  output  5x3  per output o, selected input index; NONE_PORT when output is free.
- REQ-011: xbar_valid_o  output  5  output o carries a valid flit this cycle.
- REQ-012: out_busy_o  output  5  output o is locked to a packet.
- REQ-013: protocol_err_o  output  1  one-cycle pulse on any protocol violation (REQ-024).

Function
- REQ-014: Each output o holds state FREE or LOCKED, a 3-bit owner register, and a 3-bit round-robin pointer rr[o].
- REQ-015: In FREE, input i is eligible for o iff req_i[i], req_port_i[i]==o, and req_flit_type_i[i]==HEAD.
- REQ-016: In FREE, the winner is the first eligible input searching rr[o]+1, rr[o]+2, ... modulo 5.
- REQ-017: On a winner, o goes to LOCKED with owner=winner at the next edge; no grant is issued in the allocation cycle.
- REQ-018: In LOCKED, xbar_sel_o[o]=owner, and out_busy_o[o]=1.
- REQ-019: In LOCKED, transfer occurs iff req_i[owner] && out_ready_i[o]; then grant_o[owner]=1 and xbar_valid_o[o]=1 combinationally in the same cycle.
- REQ-020: A transferred TAIL returns o to FREE at the next edge and sets rr[o]=owner; any other flit type keeps the lock.
- REQ-021: Head-to-first-grant latency is 1 cycle minimum. A released output is re-allocated no earlier than the cycle after the tail, giving a 1-cycle bubble between packets.
- REQ-022: If out_ready_i[o]=0 or the owner has no flit, the state holds, with no grant and no valid.
- REQ-023: Each input can be granted by at most one output per cycle; at most one grant bit per output is set.
- REQ-024: protocol_err_o pulses in either of these cases:
  - req_i[i] with a non-HEAD type while input i owns no output;
  - req_port_i outside 0..4 with req_i set.
  The offending request is never eligible and the state is not changed.
- REQ-025: In FREE, xbar_sel_o[o]=NONE_PORT and xbar_valid_o[o]=0.
- REQ-026: Simultaneous head requests from several inputs to different free outputs are allocated in parallel in the same cycle.

Reset
- REQ-027: rst_n=0 asynchronously forces:
  - all outputs FREE, owner=0, rr[o]=4 (input 0 has first priority);
  - grant_o=0, xbar_valid_o=0, out_busy_o=0, xbar_sel_o=NONE_PORT for all outputs, protocol_err_o=0.
- REQ-028: Reset mid-packet drops every lock without waiting for TAIL; after release, the first eligible HEAD is allocated per REQ-016.

Verification
- REQ-029: Single packet, input 0 (LOCAL) to EAST, out_ready=1, flits HEAD/BODY/BODY/TAIL -> cycle 0 allocation; grant_o[0] in cycles 1-4; xbar_sel_o[3]=0; out_busy_o[3] falls after cycle 4; rr[3]=0.
- REQ-030: Inputs 1, 2 and 4 all send HEAD to WEST from reset -> WEST is granted in order 1, 2, 4, one packet each, with a 1-cycle bubble between packets.
- REQ-031: Locked packet with out_ready toggling 1,0,0,1 -> no grant and no valid while ready=0; the flit count still reaches 4 and the lock releases only on TAIL.
- REQ-032: Input 0 sends to NORTH while input 3 sends to SOUTH in the same cycle -> both are allocated in the same cycle; grant_o=0b01001 while both outputs are ready.
- REQ-033: Error and reset cases:
  - BODY flit presented by an idle input 2 -> protocol_err_o=1 for one cycle, no allocation;
  - rst_n pulsed while WEST is locked -> out_busy_o=0 immediately; input 0 wins the next contention.
